mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master_pkg.sv | 14 +
 rtl/mem_req_fifo.sv | 43 ++++
 rtl/mem_master.sv | 120 ++++++++++++
 tb/tb_mem_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_master_pkg.sv
// Shared definitions for mem_master: FSM state encoding and default geometry.
package mem_master_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO for mem_master. Push while full and pop while empty
// are ignored; there is no bypass path from input to output.
module mem_req_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         res_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mem_master.sv
// Queued single-outstanding memory master. Define MEM_MASTER_TIMEOUT_EN to
// add the m_ready watchdog; without it WAIT only exits on m_ready.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic                  m_ready,
  input  logic [WIDTH-1:0]      m_rdata
);
  localparam int FW = 1 + ADDR_WIDTH + WIDTH;

  state_e                 state_q, state_d;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FW-1:0]          fifo_dout;
  logic                   m_wr_rd_q;
  logic [ADDR_WIDTH-1:0]  m_addr_q;
  logic [WIDTH-1:0]       m_wdata_q, rsp_rdata_q;
  logic                   tmo, done;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;

  mem_req_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk),
    .res_i  (res),
    .push_i (fifo_push),
    .din_i  ({req_wr, req_addr, req_wdata}),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign done = (state_q == ST_WAIT) && (m_ready || tmo);

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (done) state_d = m_wr_rd_q ? ST_IDLE : ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    m_valid   = (state_q == ST_ISSUE);
    rsp_valid = (state_q == ST_RESP);
  end

  // Command registers double as the memory-port outputs so they hold between issues.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      m_wr_rd_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if (fifo_pop) {m_wr_rd_q, m_addr_q, m_wdata_q} <= fifo_dout;
      if (done && !m_wr_rd_q) rsp_rdata_q <= m_ready ? m_rdata : '0;
    end
  end

  assign m_wr_rd   = m_wr_rd_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          rsp_err_q;

  // Fires on the TIMEOUT-th consecutive WAIT cycle without m_ready.
  assign tmo = (state_q == ST_WAIT) && !m_ready && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_WAIT && !m_ready) ? cnt_q + 1'b1 : '0;
      if (done && !m_wr_rd_q) rsp_err_q <= !m_ready;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: memory slave model plus in-order response scoreboard.
module tb_mem_master;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          res;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0]  rsp_rdata;
  logic          m_valid, m_wr_rd, m_ready;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wdata, m_rdata;

  mem_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory slave: captures writes on the issue pulse, serves reads combinationally.
  logic [W-1:0] mem [D];
  logic         m_ready_en;
  assign m_ready = m_ready_en;
  assign m_rdata = mem[m_addr];

  always @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (m_valid && m_wr_rd) begin
      mem[m_addr] <= m_wdata;
    end
  end

  typedef struct packed { logic [W-1:0] d; logic e; } exp_t;
  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] shadow [D];
  int           compared = 0, mismatched = 0, mv_cnt = 0, rsp_cnt = 0;
  logic         mv_prev = 1'b0;
  bit           tmo_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every handshake, checks m_valid is a single pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (res) begin
        mv_prev = 1'b0;
      end else begin
        if (m_valid) begin
          mv_cnt++;
          chk("m_valid_single_pulse_prev", mv_prev, 0);
        end
        mv_prev = m_valid;
        if (rsp_valid && rsp_ready) begin
          rsp_cnt++;
          if (sb.size() == 0) begin
            chk("unexpected_rsp_sb_size", 0, 1);
          end else begin
            mon_e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e.d);
            chk("rsp_err", rsp_err, mon_e.e);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts and ends at posedge+1; acc reports whether the request was taken.
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input int budget, output bit acc);
    acc = 1'b0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (acc) begin
      if (wr)            shadow[a] = d;
      else if (tmo_mode) sb.push_back('{d: '0, e: 1'b1});
      else               sb.push_back('{d: shadow[a], e: 1'b0});
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    bit          acc;
    int          n, base_mv, base_r;
    logic [W-1:0] wd;

    res = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; m_ready_en = 1'b1;
    for (int i = 0; i < D; i++) shadow[i] = '0;

    // Reset state
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    @(posedge clk); #1 res = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_m_wr_rd", m_wr_rd, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #1;

    // Write then read back address 3
    base_mv = mv_cnt;
    send(1'b1, 3'd3, 8'hA5, 10, acc); chk("t028_wr_accept", acc, 1);
    send(1'b0, 3'd3, 8'h00, 10, acc); chk("t028_rd_accept", acc, 1);
    wait_drain("t028_drain");
    idle(3);
    chk("t028_m_valid_pulses", mv_cnt - base_mv, 2);

    // Minimum accept-to-response latency with an empty queue
    send(1'b0, 3'd3, 8'h00, 10, acc); chk("t019_accept", acc, 1);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    chk("t019_latency_edges", n, 3);
    @(posedge clk); #1;
    wait_drain("t019_drain");

    // Queue fills while the FSM is parked in RESP
    rsp_ready = 1'b0; base_r = rsp_cnt;
    send(1'b0, 3'd3, 8'h00, 10, acc); chk("t029_first_accept", acc, 1);
    idle(5);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 3'd3, 8'h00, 3, acc); chk("t029_fill_accept", acc, 1);
    end
    @(negedge clk);
    chk("t029_req_ready_full", req_ready, 0);
    @(posedge clk); #1;
    send(1'b0, 3'd3, 8'h00, 6, acc); chk("t029_fifth_rejected", acc, 0);
    rsp_ready = 1'b1;
    wait_drain("t029_drain");
    chk("t029_rsp_count", rsp_cnt - base_r, 5);

    // Response held stable under backpressure
    rsp_ready = 1'b0; base_r = rsp_cnt;
    send(1'b0, 3'd3, 8'h00, 10, acc); chk("t030_accept", acc, 1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t030_rsp_seen", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t030_hold_valid", rsp_valid, 1);
      chk("t030_hold_rdata", rsp_rdata, 8'hA5);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t030_valid_drops", rsp_valid, 0);
    chk("t030_single_rsp", rsp_cnt - base_r, 1);
    @(posedge clk); #1;

    // Fill all addresses, then read them back in order
    base_r = rsp_cnt;
    for (int i = 0; i < D; i++) begin
      wd = 8'(8'h11 * (i + 1));
      send(1'b1, AW'(i), wd, 20, acc); chk("t033_wr_accept", acc, 1);
    end
    for (int i = 0; i < D; i++) begin
      send(1'b0, AW'(i), 8'h00, 20, acc); chk("t033_rd_accept", acc, 1);
    end
    wait_drain("t033_drain");
    chk("t033_rsp_count", rsp_cnt - base_r, 8);

`ifdef MEM_MASTER_TIMEOUT_EN
    // Watchdog: read with a dead slave returns err and zero data
    idle(5);
    m_ready_en = 1'b0; tmo_mode = 1'b1;
    send(1'b0, 3'd2, 8'h00, 10, acc); chk("t031_accept", acc, 1);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t031_issue_seen", m_valid, 1);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk("t031_issue_to_rsp_edges", n, 16);
    @(posedge clk); #1;
    tmo_mode = 1'b0; m_ready_en = 1'b1;
    wait_drain("t031_drain");
`endif

    // Reset during WAIT with two requests still queued
    idle(2);
    m_ready_en = 1'b0; base_r = rsp_cnt;
    send(1'b0, 3'd1, 8'h00, 10, acc); chk("t032_accept0", acc, 1);
    send(1'b0, 3'd2, 8'h00, 10, acc); chk("t032_accept1", acc, 1);
    send(1'b0, 3'd4, 8'h00, 10, acc); chk("t032_accept2", acc, 1);
    idle(1);
    #2 res = 1'b1;
    #1;
    chk("t032_rst_m_valid", m_valid, 0);
    chk("t032_rst_rsp_valid", rsp_valid, 0);
    chk("t032_rst_req_ready", req_ready, 1);
    sb.delete();
    @(posedge clk); #1 res = 1'b0;
    m_ready_en = 1'b1; base_mv = mv_cnt;
    idle(20);
    chk("t032_no_m_valid", mv_cnt - base_mv, 0);
    chk("t032_no_rsp", rsp_cnt - base_r, 0);
    chk("t032_req_ready", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end

endmodule
